// File: rtl/wb_skid_reg_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_skid_reg_if : valid/ready bundle bus around the writeback skid register
// Revision 1.0
// ---------------------------------------------------------------------------
interface wb_skid_reg_if #(
  parameter int DATA_W = 112,
  parameter int WE_W   = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WE_W-1:0]   in_we;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WE_W-1:0]   out_we;
  logic [DATA_W-1:0] out_data;

  // master: the stage feeding bundles in and consuming them downstream
  modport master (
    output in_valid, in_we, in_data, out_ready,
    input  in_ready, out_valid, out_we, out_data
  );

  modport slave (
    input  in_valid, in_we, in_data, out_ready,
    output in_ready, out_valid, out_we, out_data
  );
endinterface
`default_nettype wire

// File: rtl/wb_skid_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_skid_reg : mem->wb boundary register, 2-entry skid, flush, bp counter
// Revision 1.0
// ---------------------------------------------------------------------------
module wb_skid_reg #(
  parameter int DATA_W          = 112,
  parameter int WE_W            = 4,
  parameter int CLEAR_ON_BUBBLE = 1,
  parameter int CNT_W           = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_flush,
  wb_skid_reg_if.slave          bus,
  output logic [1:0]            o_occupancy,
  output logic [CNT_W-1:0]      o_bp_cycles
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [WE_W-1:0]   r_main_we;
  logic [DATA_W-1:0] r_main_data;
  logic [WE_W-1:0]   r_skid_we;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_bp;

  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_bubble_main;
  logic [DATA_W-1:0] w_bubble_skid;
  logic              w_bp_sat;

  assign w_push   = bus.in_valid && r_in_ready;
  assign w_pop    = r_out_valid && bus.out_ready;
  assign w_bp_sat = (r_bp == {CNT_W{1'b1}});

  // Data an entry takes when it goes invalid: zero, or its last value.
  assign w_bubble_main = (CLEAR_ON_BUBBLE != 0) ? '0 : r_main_data;
  assign w_bubble_skid = (CLEAR_ON_BUBBLE != 0) ? '0 : r_skid_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_we   <= '0;
      r_main_data <= '0;
      r_skid_we   <= '0;
      r_skid_data <= '0;
      r_bp        <= '0;
    end else begin
      if (r_out_valid && !bus.out_ready && !w_bp_sat)
        r_bp <= r_bp + {{(CNT_W-1){1'b0}}, 1'b1};

      if (i_flush) begin
        r_state     <= S_EMPTY;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
        r_main_we   <= '0;
        r_main_data <= w_bubble_main;
        r_skid_we   <= '0;
        r_skid_data <= w_bubble_skid;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_push) begin
              r_state     <= S_ONE;
              r_out_valid <= 1'b1;
              r_main_we   <= bus.in_we;
              r_main_data <= bus.in_data;
            end
          end
          S_ONE: begin
            if (w_push && w_pop) begin
              r_main_we   <= bus.in_we;
              r_main_data <= bus.in_data;
            end else if (w_push) begin
              // in_ready drops together with the skid fill, never from out_ready
              r_state     <= S_FULL;
              r_in_ready  <= 1'b0;
              r_skid_we   <= bus.in_we;
              r_skid_data <= bus.in_data;
            end else if (w_pop) begin
              r_state     <= S_EMPTY;
              r_out_valid <= 1'b0;
              r_main_we   <= '0;
              r_main_data <= w_bubble_main;
            end
          end
          S_FULL: begin
            if (w_pop) begin
              r_state     <= S_ONE;
              r_in_ready  <= 1'b1;
              r_main_we   <= r_skid_we;
              r_main_data <= r_skid_data;
              r_skid_we   <= '0;
              r_skid_data <= w_bubble_skid;
            end
          end
          default: begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_we   <= '0;
            r_skid_we   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_we    = r_main_we;
  assign bus.out_data  = r_main_data;
  assign o_occupancy   = r_state;
  assign o_bp_cycles   = r_bp;

endmodule
`default_nettype wire

// File: tb/tb_wb_skid_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_skid_reg : three parameter variants against a queue-based model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_wb_skid_reg;
  localparam int DW = 112;
  localparam int WW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       = 1'b1;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [WW-1:0] in_we     = '0;
  logic [DW-1:0] in_data   = '0;

  wb_skid_reg_if #(.DATA_W(DW), .WE_W(WW)) if0 ();
  wb_skid_reg_if #(.DATA_W(DW), .WE_W(WW)) if1 ();
  wb_skid_reg_if #(.DATA_W(DW), .WE_W(WW)) if2 ();

  assign if0.in_valid = in_valid;  assign if0.in_we = in_we;
  assign if0.in_data  = in_data;   assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;  assign if1.in_we = in_we;
  assign if1.in_data  = in_data;   assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;  assign if2.in_we = in_we;
  assign if2.in_data  = in_data;   assign if2.out_ready = out_ready;

  logic [1:0]  occ0, occ1, occ2;
  logic [15:0] bp0, bp1;
  logic [2:0]  bp2;

  wb_skid_reg #(.DATA_W(DW), .WE_W(WW), .CLEAR_ON_BUBBLE(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .i_flush(flush), .bus(if0),
    .o_occupancy(occ0), .o_bp_cycles(bp0));
  wb_skid_reg #(.DATA_W(DW), .WE_W(WW), .CLEAR_ON_BUBBLE(0), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .i_flush(flush), .bus(if1),
    .o_occupancy(occ1), .o_bp_cycles(bp1));
  wb_skid_reg #(.DATA_W(DW), .WE_W(WW), .CLEAR_ON_BUBBLE(1), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst(rst), .i_flush(flush), .bus(if2),
    .o_occupancy(occ2), .o_bp_cycles(bp2));

  // Reference: an ordered queue of held bundles plus an unbounded stall count.
  typedef struct packed {
    logic [WW-1:0] we;
    logic [DW-1:0] data;
  } bundle_t;

  bundle_t     q[$];
  logic [DW-1:0] m_last = '0;
  longint      bp_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_fail = 0;

  task automatic model_edge();
    bit      push, pop;
    bundle_t b;
    push = in_valid && (q.size() < 2);
    pop  = (q.size() > 0) && out_ready;
    if (rst) begin
      q.delete();
      m_last = '0;
      bp_cnt = 0;
    end else begin
      if (q.size() > 0 && !out_ready) bp_cnt++;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          b.we = in_we;
          b.data = in_data;
          q.push_back(b);
        end
      end
    end
    if (q.size() > 0) m_last = q[0].data;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int idx, input bit clr, input int w,
                           input logic ir, input logic ov, input logic [WW-1:0] we,
                           input logic [DW-1:0] data, input logic [1:0] occ,
                           input logic [15:0] bp);
    longint  mx;
    bit      has;
    has = (q.size() > 0);
    mx  = (longint'(1) << w) - 1;
    chk($sformatf("d%0d_in_ready", idx), ir, (q.size() < 2));
    chk($sformatf("d%0d_out_valid", idx), ov, has);
    chk($sformatf("d%0d_out_we", idx), we, has ? q[0].we : '0);
    chk($sformatf("d%0d_out_data", idx), data,
        has ? q[0].data : (clr ? '0 : m_last));
    chk($sformatf("d%0d_occupancy", idx), occ, q.size());
    chk($sformatf("d%0d_bp_cycles", idx), bp, (bp_cnt > mx) ? mx : bp_cnt);
  endtask

  task automatic check_all();
    check_dut(0, 1'b1, 16, if0.in_ready, if0.out_valid, if0.out_we, if0.out_data, occ0, bp0);
    check_dut(1, 1'b0, 16, if1.in_ready, if1.out_valid, if1.out_we, if1.out_data, occ1, bp1);
    check_dut(2, 1'b1, 3, if2.in_ready, if2.out_valid, if2.out_we, if2.out_data, occ2,
              {13'd0, bp2});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [15:0]  bp_saved;
    logic [127:0] r;

    // Reset with a live input that must be ignored
    rst = 1'b1; in_valid = 1'b1; in_data = 112'hAA; in_we = 4'hF;
    cycle(); cycle();
    chk("rst_in_ready", if0.in_ready, 1'b1);
    chk("rst_out_valid", if0.out_valid, 1'b0);
    chk("rst_out_we", if0.out_we, 4'h0);
    chk("rst_out_data", if0.out_data, 112'h0);
    chk("rst_bp", bp0, 16'd0);
    rst = 1'b0; in_valid = 1'b0;

    // Streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1; in_we = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'(i);
      cycle();
      chk("stream_data", if0.out_data, i);
      chk("stream_occ", occ0, 2'd1);
    end
    in_valid = 1'b0;
    cycle();

    // Back-pressure fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 112'h11; cycle();
    in_data = 112'h22; cycle();
    in_valid = 1'b0;
    chk("bp_in_ready_low", if0.in_ready, 1'b0);
    chk("bp_occ_full", occ0, 2'd2);
    bp_saved = bp0;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk("bp_hold_data", if0.out_data, 112'h11);
      chk("bp_count", bp0, bp_saved + 16'(k));
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_drain_second", if0.out_data, 112'h22);
    chk("bp_in_ready_back", if0.in_ready, 1'b1);
    cycle();
    chk("bp_drained", if0.out_valid, 1'b0);

    // Flush while full, with a competing push and pop
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 112'h11; cycle();
    in_data = 112'h22; cycle();
    bp_saved = bp0;
    flush = 1'b1; in_data = 112'h33; out_ready = 1'b1;
    cycle();
    chk("flush_out_valid", if0.out_valid, 1'b0);
    chk("flush_out_we", if0.out_we, 4'h0);
    chk("flush_occ", occ0, 2'd0);
    chk("flush_in_ready", if0.in_ready, 1'b1);
    chk("flush_bp_kept", bp0, bp_saved);
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("flush_no_c", if0.out_valid, 1'b0);
    end

    // Bubble masking in both data modes
    out_ready = 1'b1; in_valid = 1'b1; in_data = 112'h5; in_we = 4'b1111;
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    chk("bubble_hold_data", if1.out_data, 112'h5);
    chk("bubble_hold_we", if1.out_we, 4'h0);
    chk("bubble_hold_valid", if1.out_valid, 1'b0);
    chk("bubble_clear_data", if0.out_data, 112'h0);

    // Saturation of a narrow counter
    rst = 1'b1; cycle(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 112'h77;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    chk("sat_bp", bp2, 3'd7);
    out_ready = 1'b1;
    cycle(); cycle();

    // Randomised traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_data   = r[DW-1:0];
      in_we     = WW'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
